// File: rtl/ahb_lite_master_cmd_if.sv
// Command/response stream plus AHB-Lite master signals of ahb_lite_master_cmd.
// master = the bus initiator block, slave = command source, response sink and bus responder.
interface ahb_lite_master_cmd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy,
           HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy,
           HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_lite_master_cmd.sv
// AHB-Lite single-transfer master: each command becomes one NONSEQ transfer and one response pulse, 3 edges after
// acceptance on a zero-wait bus; cmd_ready falls while a held address phase is stalled or during an ERROR cycle.
module ahb_lite_master_cmd #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_lite_master_cmd_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef struct packed {
    logic                  vld;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic [DATA_WIDTH-1:0] wdata;
  } ap_t;

  typedef struct packed {
    logic                  vld;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } dp_t;

  ap_t                   r_ap;
  dp_t                   r_dp;
  logic                  r_err_cyc;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic                  r_rsp_error;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_nonseq;
  logic                  w_cmd_ready;
  logic                  w_accept;
  logic                  w_err_first;
  logic                  w_complete;

  assign w_nonseq    = r_ap.vld & ~r_err_cyc;
  assign w_cmd_ready = ~HRESET & ~r_err_cyc & (~r_ap.vld | bus.HREADY);
  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_err_first = r_dp.vld & bus.HRESP & ~bus.HREADY & ~r_err_cyc;
  assign w_complete  = r_dp.vld & bus.HREADY;

  // AP is kept across the ERROR cycles so the cancelled transfer is re-issued.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ap <= '0;
    end else if (w_accept) begin
      r_ap.vld   <= 1'b1;
      r_ap.write <= bus.cmd_write;
      r_ap.addr  <= bus.cmd_addr;
      r_ap.size  <= bus.cmd_size;
      r_ap.wdata <= bus.cmd_wdata;
    end else if (bus.HREADY && !r_err_cyc) begin
      r_ap.vld <= 1'b0;
    end
  end

  // wdata only moves on a real write so HWDATA holds between write data phases.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp <= '0;
    end else if (bus.HREADY) begin
      r_dp.vld   <= w_nonseq;
      r_dp.write <= r_ap.write;
      if (w_nonseq && r_ap.write) begin
        r_dp.wdata <= r_ap.wdata;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_cyc <= 1'b0;
    end else if (r_err_cyc && bus.HREADY) begin
      r_err_cyc <= 1'b0;
    end else if (w_err_first) begin
      r_err_cyc <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_write <= r_dp.write;
        r_rsp_error <= bus.HRESP;
        r_rsp_rdata <= r_dp.write ? '0 : bus.HRDATA;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_error = r_rsp_error;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = r_ap.vld | r_dp.vld | r_err_cyc;
  assign bus.HTRANS    = w_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = r_ap.addr;
  assign bus.HSIZE     = r_ap.size;
  assign bus.HWRITE    = r_ap.write;
  assign bus.HWDATA    = r_dp.wdata;
  assign bus.HBURST    = 3'b000;

endmodule

// File: tb/tb_ahb_lite_master_cmd.sv
// Bench for ahb_lite_master_cmd: directed timing steps followed by a randomized run against a
// transaction-level model (in-order command list, reference memory, scripted slave waits/errors).
module tb_ahb_lite_master_cmd;
  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] ERR_DATA = 32'hE0E0_E0E0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic        err;
  } cmd_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ahb_lite_master_cmd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  cmd_t        src_q[$];
  cmd_t        issued[$];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          bus_idx, rsp_idx, checks, errors, gap_pct;
  bit          src_shown;
  bit          s_vld;
  int          s_idx, s_wait, s_estage;
  logic        d_hready;
  logic [1:0]  t_htrans;
  logic [31:0] t_haddr, t_hwdata, t_rsp_rdata;
  logic [2:0]  t_hsize;
  logic        t_hwrite, t_cmd_ready, t_busy, t_rsp_valid, t_rsp_write, t_rsp_error;
  logic [31:0] t2_addr [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic push(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input int waits, input logic err);
    cmd_t c;
    c.write = w; c.addr = a; c.size = sz; c.wdata = d; c.waits = waits; c.err = err;
    src_q.push_back(c);
  endtask

  // One bus cycle: drive at negedge, sample and score 1ns later, then advance the model at posedge.
  task automatic cycle();
    cmd_t        c;
    logic [31:0] exp_rd;
    @(negedge HCLK);
    d_hready   = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = $urandom;
    if (s_vld) begin
      if (s_wait > 0) begin
        d_hready = 1'b0;
      end else if (issued[s_idx].err) begin
        bus.HRESP  = 1'b1;
        d_hready   = (s_estage == 1);
        bus.HRDATA = ERR_DATA;
      end else if (!issued[s_idx].write) begin
        bus.HRDATA = slv_rd(issued[s_idx].addr);
      end
    end
    bus.HREADY = d_hready;
    if (src_q.size() > 0 && (src_shown || $urandom_range(99) >= gap_pct)) begin
      src_shown     = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = src_q[0].write;
      bus.cmd_addr  = src_q[0].addr;
      bus.cmd_size  = src_q[0].size;
      bus.cmd_wdata = src_q[0].wdata;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    #1;
    t_htrans = bus.HTRANS;    t_haddr = bus.HADDR;     t_hwdata = bus.HWDATA;
    t_hsize = bus.HSIZE;      t_hwrite = bus.HWRITE;   t_cmd_ready = bus.cmd_ready;
    t_busy = bus.busy;        t_rsp_valid = bus.rsp_valid;
    t_rsp_write = bus.rsp_write; t_rsp_error = bus.rsp_error; t_rsp_rdata = bus.rsp_rdata;
    chk("hburst", bus.HBURST, 3'b000);
    if (t_rsp_valid) begin
      if (rsp_idx >= issued.size()) begin
        chk("rsp_unexpected", t_rsp_valid, 1'b0);
      end else begin
        c      = issued[rsp_idx];
        exp_rd = c.write ? 32'h0 : (c.err ? ERR_DATA : ref_rd(c.addr));
        if (c.write && !c.err) ref_mem[c.addr] = c.wdata;
        chk("rsp_write", t_rsp_write, c.write);
        chk("rsp_error", t_rsp_error, c.err);
        chk("rsp_rdata", t_rsp_rdata, exp_rd);
        rsp_idx++;
      end
    end
    chk("busy", t_busy, issued.size() != rsp_idx);
    if (s_vld && s_wait == 0 && issued[s_idx].err && s_estage == 1)
      chk("err2_idle", t_htrans, 2'b00);
    @(posedge HCLK);
    if (!HRESET) begin
      if (s_vld && d_hready) begin
        c = issued[s_idx];
        if (c.write) chk("hwdata", t_hwdata, c.wdata);
        if (c.write && !c.err) slv_mem[c.addr] = c.wdata;
        s_vld = 1'b0;
      end else if (s_vld) begin
        if (s_wait > 0) s_wait--;
        else s_estage = 1;
      end
      if (d_hready && t_htrans == 2'b10) begin
        if (bus_idx >= issued.size()) begin
          chk("bus_unexpected", t_htrans, 2'b00);
        end else begin
          c = issued[bus_idx];
          chk("haddr", t_haddr, c.addr);
          chk("hwrite", t_hwrite, c.write);
          chk("hsize", t_hsize, c.size);
          s_vld = 1'b1; s_idx = bus_idx; s_wait = c.waits; s_estage = 0;
          bus_idx++;
        end
      end
      if (bus.cmd_valid && t_cmd_ready) begin
        issued.push_back(src_q.pop_front());
        src_shown = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int budget;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0;
    bus.cmd_wdata = '0;   bus.HREADY = 1'b1;    bus.HRESP = 1'b0;   bus.HRDATA = '0;
    gap_pct = 0;
    t2_addr = '{32'h2, 32'h4, 32'h6, 32'h4};

    // Reset values
    #3;
    chk("rst_htrans", bus.HTRANS, 2'b00);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hsize", bus.HSIZE, 3'b000);
    chk("rst_hwrite", bus.HWRITE, 1'b0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_write", bus.rsp_write, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_error", bus.rsp_error, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    repeat (2) @(negedge HCLK);
    #2 HRESET = 1'b0;

    // Single write, zero-wait latency
    push(1'b1, 32'h4, 3'b010, 32'h4, 0, 1'b0);
    cycle(); chk("t1_cmd_ready", t_cmd_ready, 1'b1);
    cycle(); chk("t1_htrans", t_htrans, 2'b10); chk("t1_haddr", t_haddr, 32'h4); chk("t1_hwrite", t_hwrite, 1'b1);
    cycle(); chk("t1_idle", t_htrans, 2'b00); chk("t1_hwdata", t_hwdata, 32'h4); chk("t1_no_rsp", t_rsp_valid, 1'b0);
    cycle(); chk("t1_rsp_valid", t_rsp_valid, 1'b1); chk("t1_rsp_write", t_rsp_write, 1'b1);
    chk("t1_rsp_error", t_rsp_error, 1'b0);

    // Back-to-back zero-wait stream
    push(1'b0, 32'h2, 3'b010, 32'h0, 0, 1'b0);
    push(1'b1, 32'h4, 3'b010, 32'h4, 0, 1'b0);
    push(1'b1, 32'h6, 3'b010, 32'h4, 0, 1'b0);
    push(1'b0, 32'h4, 3'b010, 32'h0, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i >= 1 && i <= 4) begin
        chk("t2_nonseq", t_htrans, 2'b10);
        chk("t2_haddr", t_haddr, t2_addr[i-1]);
      end
      if (i == 4) chk("t2_hwdata", t_hwdata, 32'h4);
      chk("t2_rsp_valid", t_rsp_valid, i >= 3);
      if (i == 6) chk("t2_rdata", t_rsp_rdata, 32'h4);
    end

    // Three wait states on the first of two reads
    push(1'b0, 32'h10, 3'b010, 32'h0, 3, 1'b0);
    push(1'b0, 32'h14, 3'b001, 32'h0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (i >= 2 && i <= 5) begin
        chk("t3_hold_trans", t_htrans, 2'b10);
        chk("t3_hold_addr", t_haddr, 32'h14);
      end
      if (i >= 2 && i <= 4) chk("t3_cmd_ready", t_cmd_ready, 1'b0);
      if (i >= 2) chk("t3_rsp_valid", t_rsp_valid, i == 6 || i == 7);
    end

    // ERROR on a write with a read already in address phase
    push(1'b1, 32'h6, 3'b010, 32'hCAFE_0006, 0, 1'b1);
    push(1'b0, 32'h8, 3'b010, 32'h0, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i == 3) begin
        chk("t4_idle", t_htrans, 2'b00);
        chk("t4_addr_held", t_haddr, 32'h8);
      end
      if (i == 4) begin
        chk("t4_err_rsp", t_rsp_valid, 1'b1);
        chk("t4_err_flag", t_rsp_error, 1'b1);
        chk("t4_reissue", t_htrans, 2'b10);
        chk("t4_reissue_addr", t_haddr, 32'h8);
      end
      if (i == 5) chk("t4_gap", t_rsp_valid, 1'b0);
      if (i == 6) begin
        chk("t4_ok_rsp", t_rsp_valid, 1'b1);
        chk("t4_ok_err", t_rsp_error, 1'b0);
      end
    end

    // Reset with two commands in flight
    push(1'b1, 32'h20, 3'b010, 32'h1234_5678, 0, 1'b0);
    push(1'b0, 32'h24, 3'b010, 32'h0, 0, 1'b0);
    cycle();
    cycle();
    #2 HRESET = 1'b1;
    #1;
    chk("t5_htrans", bus.HTRANS, 2'b00);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_cmd_ready", bus.cmd_ready, 1'b0);
    chk("t5_rsp_valid", bus.rsp_valid, 1'b0);
    chk("t5_haddr", bus.HADDR, 32'h0);
    bus_idx = issued.size(); rsp_idx = issued.size(); s_vld = 1'b0;
    cycle();
    cycle();
    #2 HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_dropped", t_rsp_valid, 1'b0);
    end
    base = rsp_idx;
    push(1'b1, 32'h28, 3'b010, 32'h0BAD_F00D, 0, 1'b0);
    repeat (5) cycle();
    chk("t5_new_rsp", rsp_idx - base, 1);

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t6_htrans", t_htrans, 2'b00);
      chk("t6_busy", t_busy, 1'b0);
      chk("t6_rsp_valid", t_rsp_valid, 1'b0);
    end

    // Randomized stream with gaps, waits and errors
    gap_pct = 30;
    for (int n = 0; n < 300; n++) begin
      push(1'($urandom_range(1)), 32'($urandom_range(15)) << 2, 3'($urandom_range(2)), $urandom,
           ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0, 1'($urandom_range(9) == 0));
    end
    budget = 0;
    while ((src_q.size() > 0 || rsp_idx < issued.size()) && budget < 20000) begin
      cycle();
      budget++;
    end
    chk("drain_in_budget", budget < 20000, 1'b1);
    chk("all_responded", rsp_idx, issued.size());
    chk("all_on_bus", bus_idx, issued.size());
    repeat (3) cycle();
    chk("end_busy", t_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
